// File: rtl/q_layer_ti_serial_if.sv
// Handshake and share bus of the serial threshold-implementation Q layer.
// The slave modport is the block side; the master modport is the producer/consumer side.
interface q_layer_ti_serial_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] sh1_in;
  logic [63:0] sh2_in;
  logic [63:0] sh3_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sh1_out;
  logic [63:0] sh2_out;
  logic [63:0] sh3_out;

  modport slave (
    input  in_valid,
    input  sh1_in,
    input  sh2_in,
    input  sh3_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sh1_out,
    output sh2_out,
    output sh3_out
  );

  modport master (
    output in_valid,
    output sh1_in,
    output sh2_in,
    output sh3_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sh1_out,
    input  sh2_out,
    input  sh3_out
  );
endinterface

// File: rtl/q_layer_ti_serial.sv
// 3-share threshold implementation of the Midori64 quadratic S-box part Q,
// sweeping the 64-bit state NIB_PER_CYC nibbles per cycle into registered output shares.
module q_layer_ti_serial #(
  parameter int unsigned NIB_PER_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  q_layer_ti_serial_if.slave bus
);

  localparam int unsigned K     = 16 / NIB_PER_CYC;
  localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned GW    = 4 * NIB_PER_CYC;

  if (!(NIB_PER_CYC inside {1, 2, 4, 8, 16})) begin : g_bad_param
    $error("NIB_PER_CYC must be one of 1, 2, 4, 8, 16");
  end

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             in_ready;
  logic             out_valid;
  logic [CNT_W-1:0] cnt;
  logic             last;

  logic [63:0]      s1, s2, s3;
  logic [63:0]      o1, o2, o3;
  logic [GW-1:0]    g1, g2, g3;
  logic [GW-1:0]    r1, r2, r3;

  // a is the share that passes linearly (index i), b its companion (index j):
  // quad_(i,j)(u,v) = u_i v_i ^ u_i v_j ^ u_j v_i, applied to x2*x1 and x2*x0.
  function automatic logic [3:0] q_share(input logic [3:0] a, input logic [3:0] b);
    logic t3;
    logic t1;
    t3 = (a[2] & a[1]) ^ (a[2] & b[1]) ^ (b[2] & a[1]);
    t1 = (a[2] & a[0]) ^ (a[2] & b[0]) ^ (b[2] & a[0]);
    return {a[3] ^ t3, a[2], a[1] ^ t1, a[0]};
  endfunction

  assign last = (cnt == CNT_W'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = PROC;
        end
      end
      PROC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select the current nibble group from the captured shares only.
  always_comb begin
    g1 = '0;
    g2 = '0;
    g3 = '0;
    for (int unsigned g = 0; g < K; g++) begin
      if (cnt == CNT_W'(g)) begin
        g1 = s1[g*GW +: GW];
        g2 = s2[g*GW +: GW];
        g3 = s3[g*GW +: GW];
      end
    end
  end

  // Output share i never sees input share i (non-completeness).
  always_comb begin
    r1 = '0;
    r2 = '0;
    r3 = '0;
    for (int unsigned l = 0; l < NIB_PER_CYC; l++) begin
      r1[4*l +: 4] = q_share(g2[4*l +: 4], g3[4*l +: 4]);
      r2[4*l +: 4] = q_share(g3[4*l +: 4], g1[4*l +: 4]);
      r3[4*l +: 4] = q_share(g1[4*l +: 4], g2[4*l +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      o1  <= '0;
      o2  <= '0;
      o3  <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        s1  <= bus.sh1_in;
        s2  <= bus.sh2_in;
        s3  <= bus.sh3_in;
        cnt <= '0;
      end
      if (state == PROC) begin
        for (int unsigned g = 0; g < K; g++) begin
          if (cnt == CNT_W'(g)) begin
            o1[g*GW +: GW] <= r1;
            o2[g*GW +: GW] <= r2;
            o3[g*GW +: GW] <= r3;
          end
        end
        if (!last) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sh1_out   = o1;
  assign bus.sh2_out   = o2;
  assign bus.sh3_out   = o3;

endmodule

// File: tb/tb_q_layer_ti_serial.sv
// Bench for q_layer_ti_serial: three instances (4, 1 and 16 nibbles/cycle) driven in lockstep,
// checked against a nibble-table model of Q and an algebraic model of each output share.
module tb_q_layer_ti_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] sh1, sh2, sh3;

  always #5 clk = ~clk;

  q_layer_ti_serial_if bus4 ();
  q_layer_ti_serial_if bus1 ();
  q_layer_ti_serial_if bus16 ();

  assign bus4.in_valid   = in_valid;
  assign bus4.out_ready  = out_ready;
  assign bus4.sh1_in     = sh1;
  assign bus4.sh2_in     = sh2;
  assign bus4.sh3_in     = sh3;
  assign bus1.in_valid   = in_valid;
  assign bus1.out_ready  = out_ready;
  assign bus1.sh1_in     = sh1;
  assign bus1.sh2_in     = sh2;
  assign bus1.sh3_in     = sh3;
  assign bus16.in_valid  = in_valid;
  assign bus16.out_ready = out_ready;
  assign bus16.sh1_in    = sh1;
  assign bus16.sh2_in    = sh2;
  assign bus16.sh3_in    = sh3;

  q_layer_ti_serial #(.NIB_PER_CYC(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  q_layer_ti_serial #(.NIB_PER_CYC(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  q_layer_ti_serial #(.NIB_PER_CYC(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Index 0: 4 nibbles/cycle, 1: 1 nibble/cycle, 2: 16 nibbles/cycle.
  logic        ov [3];
  logic        ir [3];
  logic [63:0] o1 [3];
  logic [63:0] o2 [3];
  logic [63:0] o3 [3];
  assign ov[0] = bus4.out_valid;   assign ir[0] = bus4.in_ready;
  assign ov[1] = bus1.out_valid;   assign ir[1] = bus1.in_ready;
  assign ov[2] = bus16.out_valid;  assign ir[2] = bus16.in_ready;
  assign o1[0] = bus4.sh1_out;  assign o2[0] = bus4.sh2_out;  assign o3[0] = bus4.sh3_out;
  assign o1[1] = bus1.sh1_out;  assign o2[1] = bus1.sh2_out;  assign o3[1] = bus1.sh3_out;
  assign o1[2] = bus16.sh1_out; assign o2[2] = bus16.sh2_out; assign o3[2] = bus16.sh3_out;

  localparam int EXP_LAT [3] = '{4, 16, 1};
  localparam logic [3:0] QTAB [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hE, 4'hD,
                                      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'h6, 4'h5};

  int          n_vec = 0;
  int          n_err = 0;
  int          lat [3];
  logic [63:0] r1 [3];
  logic [63:0] r2 [3];
  logic [63:0] r3 [3];

  typedef struct {
    logic [63:0] s1, s2, s3;
    logic [63:0] e1, e2, e3;
  } vec_t;
  vec_t vt [5];

  function automatic logic [63:0] q64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = QTAB[x[4*n +: 4]];
    return y;
  endfunction

  // Linear share si plus quad_(i,j), using quad = (u_i^u_j)(v_i^v_j) ^ u_j v_j.
  function automatic logic [63:0] ref_share(input logic [63:0] si, input logic [63:0] sj);
    logic [63:0] r;
    logic [3:0]  a, b;
    r = si;
    for (int n = 0; n < 16; n++) begin
      a = si[4*n +: 4];
      b = sj[4*n +: 4];
      r[4*n+3] = r[4*n+3] ^ (((a[2] ^ b[2]) & (a[1] ^ b[1])) ^ (b[2] & b[1]));
      r[4*n+1] = r[4*n+1] ^ (((a[2] ^ b[2]) & (a[0] ^ b[0])) ^ (b[2] & b[0]));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Accept one state in all three instances and record when each raises out_valid.
  task automatic transact(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bit seen [3];
    sh1 = a; sh2 = b; sh3 = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      seen[d] = 1'b0;
      lat[d]  = -1;
      r1[d] = 'x; r2[d] = 'x; r3[d] = 'x;
    end
    for (int cyc = 1; cyc <= 20 && !(seen[0] && seen[1] && seen[2]); cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          lat[d]  = cyc;
          r1[d] = o1[d]; r2[d] = o2[d]; r3[d] = o3[d];
        end
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [63:0] x, m1, m2, b1, b2, b3, base;
  int          bit_pos;

  initial begin
    vt[0] = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h012347ED89ABCF65};
    vt[1] = '{64'h0, 64'h0123456789ABCDEF, 64'h0, 64'h012347ED89ABCF65, 64'h0, 64'h0};
    vt[2] = '{64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0, 64'h012347ED89ABCF65, 64'h0};
    vt[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h5555555555555555};
    vt[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,
              64'h5555555555555555, 64'h0, 64'h5555555555555555};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sh1 = '0; sh2 = '0; sh3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(ir[0]), 64'd1);
    check("reset out_valid", 64'(ov[0]), 64'd0);
    check("reset sh1_out", o1[0], 64'h0);
    check("reset sh2_out", o2[0], 64'h0);
    check("reset sh3_out", o3[0], 64'h0);
    rst = 1'b0;

    // Fixed vectors, also used as the parameter sweep across all three instances.
    for (int v = 0; v < 5; v++) begin
      transact(vt[v].s1, vt[v].s2, vt[v].s3);
      for (int d = 0; d < 3; d++) begin
        check("table latency", 64'(lat[d]), 64'(EXP_LAT[d]));
        check("table sh1_out", r1[d], vt[v].e1);
        check("table sh2_out", r2[d], vt[v].e2);
        check("table sh3_out", r3[d], vt[v].e3);
      end
      release_out();
    end

    // Random masked states.
    for (int i = 0; i < 1000; i++) begin
      x  = {$urandom, $urandom};
      m1 = {$urandom, $urandom};
      m2 = {$urandom, $urandom};
      transact(m1, m2, x ^ m1 ^ m2);
      check("rand latency", 64'(lat[0]), 64'd4);
      check("rand sh1_out", r1[0], ref_share(m2, x ^ m1 ^ m2));
      check("rand sh2_out", r2[0], ref_share(x ^ m1 ^ m2, m1));
      check("rand sh3_out", r3[0], ref_share(m1, m2));
      for (int d = 0; d < 3; d++) check("rand recombined", r1[d] ^ r2[d] ^ r3[d], q64(x));
      release_out();
    end

    // Non-completeness: flipping input share k must leave output share k untouched.
    b1 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    b3 = {$urandom, $urandom};
    for (int k = 1; k <= 3; k++) begin
      transact(b1, b2, b3);
      base = (k == 1) ? r1[0] : (k == 2) ? r2[0] : r3[0];
      release_out();
      for (int t = 0; t < 6; t++) begin
        bit_pos = $urandom_range(63, 0);
        transact(k == 1 ? b1 ^ (64'd1 << bit_pos) : b1,
                 k == 2 ? b2 ^ (64'd1 << bit_pos) : b2,
                 k == 3 ? b3 ^ (64'd1 << bit_pos) : b3);
        check("noncomplete share", (k == 1) ? r1[0] : (k == 2) ? r2[0] : r3[0], base);
        release_out();
      end
    end

    // Backpressure: hold in DONE with a competing in_valid.
    transact(vt[0].s1, vt[0].s2, vt[0].s3);
    sh1 = 64'hDEADBEEFCAFEF00D; sh2 = 64'h1; sh3 = 64'h2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold out_valid", 64'(ov[0]), 64'd1);
      check("hold in_ready", 64'(ir[0]), 64'd0);
      check("hold sh3_out", o3[0], vt[0].e3);
      check("hold sh1_out", o1[0], vt[0].e1);
    end
    in_valid = 1'b0;
    release_out();
    check("release in_ready", 64'(ir[0]), 64'd1);
    check("release out_valid", 64'(ov[0]), 64'd0);
    transact(vt[3].s1, vt[3].s2, vt[3].s3);
    check("after hold latency", 64'(lat[0]), 64'd4);
    check("after hold sh3_out", r3[0], vt[3].e3);
    release_out();

    // Reset after two PROC cycles.
    sh1 = vt[0].s1; sh2 = '0; sh3 = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset out_valid", 64'(ov[0]), 64'd0);
    check("midreset in_ready", 64'(ir[0]), 64'd1);
    check("midreset sh1_out", o1[0], 64'h0);
    check("midreset sh2_out", o2[0], 64'h0);
    check("midreset sh3_out", o3[0], 64'h0);
    transact(vt[1].s1, vt[1].s2, vt[1].s3);
    for (int d = 0; d < 3; d++) begin
      check("post reset latency", 64'(lat[d]), 64'(EXP_LAT[d]));
      check("post reset sh1_out", r1[d], vt[1].e1);
      check("post reset sh2_out", r2[d], vt[1].e2);
      check("post reset sh3_out", r3[d], vt[1].e3);
    end
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/q_layer_ti_serial.md
Name: q_layer_ti_serial

Overview:
- 3-share threshold implementation (TI) of the quadratic S-box component Q for the full 64-bit Midori64 state.
- Processes NIB_PER_CYC nibbles per cycle.
- Its registered output shares feed the downstream per-share affine output layer (A3), which consumers apply to each share independently.
- The output register is the TI pipeline boundary between Q and the affine layer. No fresh randomness is used.

Parameters:
NIB_PER_CYC, 4, nibbles processed per cycle; legal values 1, 2, 4, 8, 16; K = 16/NIB_PER_CYC cycles per state

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input shares valid
in_ready  output  1  block can accept a state
sh1_in  input  64  input share 1; nibble k = bits [4k+3:4k]
sh2_in  input  64  input share 2
sh3_in  input  64  input share 3
out_valid  output  1  output shares valid
out_ready  input  1  consumer accepts output
sh1_out  output  64  output share 1
sh2_out  output  64  output share 2
sh3_out  output  64  output share 3

Behaviour:
- Unshared Q per nibble x = x3 x2 x1 x0:
  - y3 = x3 ^ x2·x1
  - y2 = x2
  - y1 = x1 ^ x2·x0
  - y0 = x0
- Sharing: quad_(i,j)(a,b) = a_i·b_i ^ a_i·b_j ^ a_j·b_i.
  - out1 = linear(share2) ^ quad_(2,3)
  - out2 = linear(share3) ^ quad_(3,1)
  - out3 = linear(share1) ^ quad_(1,2)
  - The linear part is identity on the share. Quadratic terms are applied to the bits x2·x1 (into y3) and x2·x0 (into y1).
- Non-completeness: output share i never depends on input share i. This is checked structurally.
- FSM states: IDLE, PROC, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready: capture all three input shares into internal state registers, cnt←0, go to PROC.
  - PROC: in_ready=0.
    - Each edge computes group cnt, i.e. nibbles cnt·NIB_PER_CYC .. cnt·NIB_PER_CYC+NIB_PER_CYC-1, from the internal registers only (never from the *_in ports).
    - Results are written into the corresponding nibbles of the sh*_out registers; cnt←cnt+1.
    - At the edge processing cnt=K-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE (one bubble cycle before the next accept).
- Latency: out_valid rises exactly K cycles after the accept edge (4 cycles at default).
- sh*_out and out_valid hold stable while out_valid=1 and out_ready=0, for any duration.
- sh*_out contents are not meaningful outside DONE. Nibbles not yet written in PROC keep their old values. The consumer qualifies on out_valid.
- in_valid while busy is ignored: no capture, no state change.
- out_ready outside DONE is ignored.
- Reset, any state including mid-PROC: state←IDLE, cnt←0, out_valid=0, in_ready=1 after the edge, sh*_out←0, internal share registers←0. A partially processed state is discarded.
- cnt width is max(1, clog2(K)). The wrap-around of cnt is never used; the FSM leaves PROC at K-1.

Test Plan:
- Unshared: sh1_in=0x0123456789ABCDEF, sh2_in=sh3_in=0 → after K cycles sh3_out=0x012347ED89ABCF65, sh1_out=sh2_out=0, out_valid=1.
- Random 3-share: 1000 random states with random masks; check sh1_out^sh2_out^sh3_out = Q(sh1_in^sh2_in^sh3_in) per nibble. Full-table check against Q = {0,1,2,3,4,7,E,D,8,9,A,B,C,F,6,5}.
- Non-completeness: toggle single bits of sh1_in with sh2_in and sh3_in fixed → sh1_out unchanged. Repeat cyclically for shares 2 and 3.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 → outputs constant, in_ready=0, no new capture. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-PROC: assert rst after 2 PROC cycles → next cycle out_valid=0, in_ready=1, sh*_out=0. A new accept then completes in exactly K cycles with correct results.
- Parameter sweep: NIB_PER_CYC ∈ {1, 16} → latencies 16 and 1 cycles, same results as the unshared test.
